// File: rtl/spi_pkg.sv
// Definitions shared by the SPI link: word width, receiver state set and
// the mode-0 sampling edge.
package spi_pkg;

  localparam int SPI_DATA_W = 12;

  // Mode 0: data is sampled on the rising edge of sclk.
  localparam logic SAMPLE_ON_RISE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    CAPTURE = 2'd2,
    WAIT_CS = 2'd3
  } rx_state_e;

  function automatic logic edge_seen(input logic cur, input logic prev,
                                     input logic rising);
    return rising ? (cur & ~prev) : (~cur & prev);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable
// reset value so idle-high signals such as cs come out of reset inactive.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples sclk/cs/mosi in the clk domain,
// assembles one MSB-first word per cs-low frame, and hands it downstream.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              done,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, cs_rise, cs_fall;

  logic sclk_prev_q, sclk_prev_d;
  logic cs_prev_q, cs_prev_d;
  rx_state_e state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic rx_valid_q, rx_valid_d;
  logic done_q, done_d;
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs), .q(cs_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  assign sclk_rise = edge_seen(sclk_s, sclk_prev_q, SAMPLE_ON_RISE);
  assign cs_rise   = edge_seen(cs_s, cs_prev_q, 1'b1);
  assign cs_fall   = edge_seen(cs_s, cs_prev_q, 1'b0);

  always_comb begin
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    dout_d      = dout_q;
    rx_valid_d  = rx_valid_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end

      RECV: begin
        // cs release wins over a coincident sclk edge: the frame is over.
        if (cs_rise) begin
          frame_err_d = (bit_cnt_q != '0);
          state_d     = IDLE;
        end else if (sclk_rise) begin
          shreg_d   = {shreg_q[DATA_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = CAPTURE;
          end
        end
      end

      CAPTURE: begin
        if (!rx_valid_q || rx_ready) begin
          dout_d     = shreg_q;
          rx_valid_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        // A cs release seen during this cycle must not be lost.
        state_d = cs_rise ? IDLE : WAIT_CS;
      end

      WAIT_CS: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      dout_q      <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      dout_q      <= dout_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign dout      = dout_q;
  assign rx_valid  = rx_valid_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: a frame-level model predicts each
// done/frame_err event, and a monitor pops and compares as they appear.
module tb_spi_slave_rx;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk = 1'b0;
  logic         cs = 1'b1;
  logic         mosi = 1'b0;
  logic [W-1:0] dout;
  logic         rx_valid;
  logic         rx_ready = 1'b0;
  logic         done;
  logic         overrun;
  logic         frame_err;

  spi_slave_rx #(.DATA_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .dout(dout), .rx_valid(rx_valid), .rx_ready(rx_ready), .done(done),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_ferr;
    logic [W-1:0] word;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  bit           m_pending = 1'b0;
  bit           m_overrun = 1'b0;
  logic [W-1:0] m_dout = '0;
  bit           prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done / frame_err pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done && frame_err) check("done_ferr_exclusive", 1, 0);
      if (done) begin
        check("done_one_cycle", prev_done, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_is_done", done, !e.is_ferr);
          check("done_dout", dout, e.word);
        end
      end else if (frame_err) begin
        if (sb.size() == 0) begin
          check("unexpected_frame_err", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_is_frame_err", frame_err, e.is_ferr);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Frame-level model: what the receiver must do with one cs-low frame.
  task automatic model_frame(input logic [W-1:0] w, input int nedges,
                             input bit ready_hold);
    exp_t e;
    if (ready_hold) m_pending = 1'b0;
    if (nedges >= W) begin
      if (!m_pending || ready_hold) begin
        e.is_ferr = 1'b0;
        e.word    = w;
        sb.push_back(e);
        m_dout    = w;
        m_pending = !ready_hold;
      end else begin
        m_overrun = 1'b1;
      end
    end else if (nedges > 0) begin
      e.is_ferr = 1'b1;
      e.word    = '0;
      sb.push_back(e);
    end
  endtask

  task automatic drive_bits(input logic [W-1:0] w, input int nedges);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nedges; i++) begin
      mosi = (i < W) ? w[W-1-i] : 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_dout"}, dout, m_dout);
    check({tag, "_rx_valid"}, rx_valid, m_pending);
    check({tag, "_overrun"}, overrun, m_overrun);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int nedges,
                            input bit ready_hold, input string tag);
    int budget;
    rx_ready = ready_hold;
    model_frame(w, nedges, ready_hold);
    drive_bits(w, nedges);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 30) begin
      @(negedge clk);
      budget++;
    end
    check({tag, "_sb_drained"}, sb.size(), 0);
    repeat (8) @(negedge clk);
    rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_state(tag);
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    m_pending = 1'b0;
    @(negedge clk);
    check({tag, "_rx_valid_after_accept"}, rx_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  task automatic model_reset();
    sb.delete();
    m_pending = 1'b0;
    m_overrun = 1'b0;
    m_dout    = '0;
  endtask

  task automatic release_reset();
    cs = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    send_frame(12'hA5A, 12, 1'b0, "a5a_pending");
    send_frame(12'h3C3, 12, 1'b0, "overrun");
    accept("overrun");

    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("reset2");
    release_reset();

    send_frame(12'hA5A, 12, 1'b0, "first_of_two");
    accept("first_of_two");
    send_frame(12'h3C3, 12, 1'b1, "ready_held");

    send_frame(12'h000, 5, 1'b0, "short5");
    send_frame(12'h123, 12, 1'b0, "after_short");
    accept("after_short");

    send_frame(12'hFFF, 14, 1'b0, "extra_edges");

    // Abort mid-frame with a word still pending, so the clear is visible.
    drive_bits(12'h555, 6);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs("reset_mid");
    release_reset();
    send_frame(12'h800, 12, 1'b0, "post_reset");

    for (int n = 0; n < 24; n++) begin
      int           kind;
      int           ne;
      logic [W-1:0] w;
      bit           rh;
      kind = $urandom_range(0, 9);
      w    = W'($urandom);
      rh   = 1'($urandom_range(0, 1));
      if (kind < 2)       ne = $urandom_range(1, W - 1);
      else if (kind == 2) ne = $urandom_range(W + 1, W + 3);
      else                ne = W;
      send_frame(w, ne, rh, "rand");
      if (m_pending && $urandom_range(0, 2) == 0) accept("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
SPI receiver (slave end) for the 12-bit spi master link. It oversamples the master's sclk, cs and mosi in the local clk domain and shifts in one MSB-first word per cs-low frame, in SPI mode 0 (sample on sclk rising edge). It presents each received word on a valid/ready interface to downstream logic and flags overrun and short-frame errors.

Parameters:
DATA_W, 12, bits per frame; must equal the master word width.
SYNC_STAGES, 2, flop stages in each input synchronizer (minimum 2).

Ports:
clk  input  1  system clock; sclk frequency must not exceed clk/4.
rst_n  input  1  asynchronous active-low reset.
sclk  input  1  SPI clock from master; idle low (mode 0).
cs  input  1  chip select from master, active low.
mosi  input  1  serial data from master, MSB first.
dout  output  DATA_W  last accepted word.
rx_valid  output  1  dout holds an unconsumed word.
rx_ready  input  1  consumer accepts dout when rx_valid && rx_ready.
done  output  1  one-cycle pulse when a full word is captured into dout.
overrun  output  1  sticky; a word completed while rx_valid was 1.
frame_err  output  1  one-cycle pulse when cs rises mid-word.

Behaviour:
- Reset (async, rst_n=0): dout=0, rx_valid=0, done=0, overrun=0, frame_err=0. Also clears the shift register, bit_cnt and synchronizer flops, and sets state=IDLE. Synchronizers reset to sclk=0, cs=1, mosi=0.
- Reset mid-frame discards the partial word. After release, the block waits in IDLE for a fresh cs falling edge.
- Inputs pass through SYNC_STAGES flops. Edge detect compares the synchronized value with a one-cycle-delayed copy.
- Latency from a pin edge to internal action is SYNC_STAGES+1 clk cycles.
- States:
  IDLE: wait for synchronized cs falling edge, then go to RECV with bit_cnt=0.
  RECV: on each sclk rising edge, shreg <= {shreg[DATA_W-2:0], mosi_s} and bit_cnt++. mosi_s is sampled in the same cycle the edge is detected.
  When the edge that makes bit_cnt reach DATA_W occurs, go to CAPTURE.
  If cs rises in RECV with 0 < bit_cnt < DATA_W, pulse frame_err and go to IDLE; dout is unchanged.
  If cs rises in RECV with bit_cnt=0, go to IDLE silently.
  CAPTURE (1 cycle):
    If rx_valid=0, or the consumer accepts in this same cycle: dout <= shreg, rx_valid=1, done=1.
    Otherwise: set overrun=1, drop the word, and keep dout unchanged.
    Then go to WAIT_CS.
  WAIT_CS: ignore further sclk edges. On cs rising edge go to IDLE.
- A cs rising and falling edge within the same synchronized sample window is not a valid frame. Only a detected rise followed by a detected fall starts a new frame.
- rx_valid clears on the cycle after rx_valid && rx_ready. A simultaneous capture and accept keeps rx_valid=1 with the new dout.
- overrun clears only on reset.
- done and frame_err are registered outputs and are never high in the same cycle.
- bit_cnt width is $clog2(DATA_W+1) and never wraps; extra edges are ignored.

Decomposition:
- Shared package spi_pkg: SPI_DATA_W=12 (shared with the master), state enum (IDLE, RECV, CAPTURE, WAIT_CS), and the mode-0 sampling-edge constant.
- Sub-module spi_sync: a SYNC_STAGES-deep synchronizer with a reset value parameter. It is instantiated three times, for sclk, cs and mosi.

Test Plan:
- Master frame with din=0xA5A, clk/8 sclk, rx_ready=0 -> dout=0xA5A, done pulses for exactly 1 cycle, rx_valid=1, frame_err=0, overrun=0.
- With 0xA5A still pending (rx_ready=0), send 0x3C3 -> overrun=1, dout stays 0xA5A. Then pulse rx_ready -> rx_valid=0.
- Send 0xA5A, accept, then send 0x3C3 with rx_ready held 1 -> dout=0x3C3, two done pulses, overrun=0.
- Raise cs after 5 sclk edges -> frame_err pulses once, no done, dout unchanged. The next full frame 0x123 is received correctly.
- Drive 14 sclk edges in one cs-low frame of 0xFFF -> dout=0xFFF, and the extra 2 edges have no effect.
- Assert rst_n=0 after 6 bits -> all outputs 0 immediately (asynchronous). After release, frame 0x800 -> dout=0x800.
